// File: rtl/cpu_pkg.sv
// Shared types and constants for the 10-bit CPU sequencer.
// Holds the state enum, opcode/ALU codes and instruction field positions.
package cpu_pkg;

  localparam int INSTR_W = 10;
  localparam int RA_W    = 3;

  localparam int OP_LSB = 7;
  localparam int RS_LSB = 4;
  localparam int RT_LSB = 1;
  localparam int F_BIT  = 0;

  localparam logic [2:0] OP_SYS = 3'b111;
  localparam logic       F_HALT = 1'b1;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SHL = 3'b101;
  localparam logic [2:0] ALU_SHR = 3'b110;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_WB,
    ST_HALTED
  } state_t;

  function automatic logic [2:0] fld3(
    input logic [INSTR_W-1:0] ir,
    input int                 lsb
  );
    return ir[lsb +: 3];
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational IR decode: register addresses, ALU select, op class.
// Ports: ir in; raddr1/raddr2/waddr/alu_ctrl, is_halt/is_brz out.
module instr_decode
  import cpu_pkg::*;
(
  input  logic [INSTR_W-1:0] ir,
  output logic [RA_W-1:0]    raddr1,
  output logic [RA_W-1:0]    raddr2,
  output logic [RA_W-1:0]    waddr,
  output logic [2:0]         alu_ctrl,
  output logic               is_halt,
  output logic               is_brz
);

  logic [2:0] op;
  logic [2:0] rs;
  logic [2:0] rt;
  logic       f;

  assign op = fld3(ir, OP_LSB);
  assign rs = fld3(ir, RS_LSB);
  assign rt = fld3(ir, RT_LSB);
  assign f  = ir[F_BIT];

  always_comb begin
    raddr1   = rs;
    raddr2   = rt;
    waddr    = rt;
    alu_ctrl = op;
    is_halt  = 1'b0;
    is_brz   = 1'b0;
    unique case (1'b1)
      (op == OP_SYS && f == F_HALT): begin
        is_halt  = 1'b1;
        alu_ctrl = ALU_ADD;
      end
      (op == OP_SYS && f != F_HALT): begin
        is_brz   = 1'b1;
        alu_ctrl = ALU_ADD;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle fetch/decode/exec/writeback sequencer for the 10-bit core.
// Ports: imem req/ack fetch, regfile addr/we, alu_ctrl, pc_inc/branch, status.
module cpu_seq_ctrl
  import cpu_pkg::*;
#(
  parameter int IMEM_TIMEOUT = 255,
  parameter int CNT_W        = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [9:0]         pc,
  output logic               imem_req,
  input  logic               imem_ack,
  input  logic [9:0]         imem_rdata,
  output logic               pc_inc,
  output logic               branch,
  output logic [9:0]         branch_addr,
  output logic [2:0]         raddr1,
  output logic [2:0]         raddr2,
  output logic [2:0]         waddr,
  output logic               we,
  input  logic [9:0]         rdata1,
  input  logic [9:0]         rdata2,
  output logic [2:0]         alu_ctrl,
  input  logic               alu_halt,
  output logic               busy,
  output logic               halted,
  output logic               fault,
  output logic [CNT_W-1:0]   retired
);

  localparam int WAIT_W = $clog2(IMEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    WAIT_W'(IMEM_TIMEOUT - 1);

  state_t            state;
  logic [9:0]        ir;
  logic [WAIT_W-1:0] wait_cnt;
  logic              is_halt;
  logic              is_brz;
  logic              brz_taken;
  logic              unused_pc;

  // pc only addresses instruction memory outside this block
  assign unused_pc = ^pc;

  assign brz_taken = (rdata2 == '0);

  instr_decode u_dec (
    .ir       (ir),
    .raddr1   (raddr1),
    .raddr2   (raddr2),
    .waddr    (waddr),
    .alu_ctrl (alu_ctrl),
    .is_halt  (is_halt),
    .is_brz   (is_brz)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      ir          <= '0;
      wait_cnt    <= '0;
      imem_req    <= 1'b0;
      pc_inc      <= 1'b0;
      branch      <= 1'b0;
      we          <= 1'b0;
      branch_addr <= '0;
      busy        <= 1'b0;
      halted      <= 1'b0;
      fault       <= 1'b0;
      retired     <= '0;
    end else begin
      we     <= 1'b0;
      pc_inc <= 1'b0;
      branch <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_FETCH;
            imem_req <= 1'b1;
            busy     <= 1'b1;
            wait_cnt <= '0;
          end
        end
        ST_FETCH: begin
          // ack beats a timeout landing in the same cycle
          if (imem_ack) begin
            ir       <= imem_rdata;
            imem_req <= 1'b0;
            state    <= ST_DECODE;
          end else if (wait_cnt == WAIT_LAST) begin
            imem_req <= 1'b0;
            fault    <= 1'b1;
            busy     <= 1'b0;
            halted   <= 1'b1;
            state    <= ST_HALTED;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        ST_DECODE: begin
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (is_halt || (!is_brz && alu_halt)) begin
            busy   <= 1'b0;
            halted <= 1'b1;
            state  <= ST_HALTED;
          end else if (is_brz) begin
            // the branch pulse itself carries the latched taken flag
            branch_addr <= rdata1;
            branch      <= brz_taken;
            pc_inc      <= !brz_taken;
            state       <= ST_WB;
          end else begin
            we     <= 1'b1;
            pc_inc <= 1'b1;
            state  <= ST_WB;
          end
        end
        ST_WB: begin
          retired  <= retired + CNT_W'(1);
          imem_req <= 1'b1;
          wait_cnt <= '0;
          state    <= ST_FETCH;
        end
        ST_HALTED: begin
          if (start) begin
            fault    <= 1'b0;
            halted   <= 1'b0;
            busy     <= 1'b1;
            imem_req <= 1'b1;
            wait_cnt <= '0;
            state    <= ST_FETCH;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Directed bench for cpu_seq_ctrl with regfile, ALU, PC and imem models.
// Ports: none; drives the DUT and reports a summary line.
module tb_cpu_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [9:0]  pc;
  logic        imem_req;
  logic        imem_ack = 1'b0;
  logic [9:0]  imem_rdata = '0;
  logic        pc_inc;
  logic        branch;
  logic [9:0]  branch_addr;
  logic [2:0]  raddr1;
  logic [2:0]  raddr2;
  logic [2:0]  waddr;
  logic        we;
  logic [9:0]  rdata1;
  logic [9:0]  rdata2;
  logic [2:0]  alu_ctrl;
  logic        alu_halt;
  logic        busy;
  logic        halted;
  logic        fault;
  logic [15:0] retired;

  logic [9:0] regs [8] =
    '{10'd0, 10'd5, 10'd7, 10'd2, 10'h155, 10'd0, 10'd1, 10'd0};
  logic [9:0] imem [1024];
  logic [9:0] wdata;
  int         ack_delay;
  int         req_cnt = 0;

  int checks = 0;
  int errors = 0;

  logic [2:0] last_waddr;
  logic [9:0] last_wdata;
  logic [9:0] last_baddr;

  cpu_seq_ctrl #(
    .IMEM_TIMEOUT (4),
    .CNT_W        (16)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .pc          (pc),
    .imem_req    (imem_req),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .pc_inc      (pc_inc),
    .branch      (branch),
    .branch_addr (branch_addr),
    .raddr1      (raddr1),
    .raddr2      (raddr2),
    .waddr       (waddr),
    .we          (we),
    .rdata1      (rdata1),
    .rdata2      (rdata2),
    .alu_ctrl    (alu_ctrl),
    .alu_halt    (alu_halt),
    .busy        (busy),
    .halted      (halted),
    .fault       (fault),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] alu_model(
    input logic [2:0] op,
    input logic [9:0] a,
    input logic [9:0] b
  );
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return a ^ b;
      3'b101:  return a << b[3:0];
      3'b110:  return a >> b[3:0];
      default: return '0;
    endcase
  endfunction

  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];
  assign wdata  = alu_model(alu_ctrl, rdata1, rdata2);

  always @(posedge clk)
    if (we) regs[waddr] <= wdata;

  always @(posedge clk or negedge reset_n)
    if (!reset_n)    pc <= '0;
    else if (branch) pc <= branch_addr;
    else if (pc_inc) pc <= pc + 10'd1;

  always @(negedge clk) begin
    if (imem_req) begin
      if (req_cnt == ack_delay) begin
        imem_ack   <= 1'b1;
        imem_rdata <= imem[pc];
      end else begin
        imem_ack <= 1'b0;
      end
      req_cnt <= req_cnt + 1;
    end else begin
      imem_ack <= 1'b0;
      req_cnt  <= 0;
    end
  end

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Starts on a FETCH sample; ends after WB or on the halted sample.
  task automatic run_instr(
    input  int dly,
    output int cyc,
    output int req,
    output int wes,
    output int incs,
    output int brs
  );
    bit done;
    done = 1'b0;
    cyc = 0; req = 0; wes = 0; incs = 0; brs = 0;
    ack_delay = dly;
    for (int i = 0; i < 40 && !done; i++) begin
      if (halted) begin
        done = 1'b1;
      end else begin
        cyc++;
        req  += int'(imem_req);
        wes  += int'(we);
        incs += int'(pc_inc);
        brs  += int'(branch);
        if (we) begin
          last_waddr = waddr;
          last_wdata = wdata;
        end
        if (branch) last_baddr = branch_addr;
        if (pc_inc || branch) done = 1'b1;
        tick();
      end
    end
    check("instr_done", 32'(done), 32'd1);
  endtask

  int cyc, req, wes, incs, brs;

  initial begin
    for (int i = 0; i < 1024; i++) imem[i] = '0;
    imem[0]      = 10'h014;
    imem[1]      = 10'h096;
    imem[2]      = 10'h214;
    imem[3]      = 10'h3CA;
    imem[10'h155] = 10'h3CC;
    imem[10'h156] = 10'h381;

    reset_n   = 1'b0;
    start     = 1'b0;
    alu_halt  = 1'b0;
    ack_delay = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ctl", 32'({imem_req, pc_inc, branch, we, busy,
      halted, fault, raddr1, raddr2, waddr, alu_ctrl}), 32'd0);
    check("rst_cnt", 32'({retired, branch_addr}), 32'd0);
    reset_n = 1'b1;
    tick();
    check("idle_hold", 32'({busy, halted, imem_req}), 32'd0);

    pulse_start();
    check("fetch_req", 32'({imem_req, busy}), 32'b11);
    run_instr(0, cyc, req, wes, incs, brs);
    check("add_cyc", cyc, 4);
    check("add_req", req, 1);
    check("add_we", wes, 1);
    check("add_inc", incs, 1);
    check("add_br", brs, 0);
    check("add_waddr", 32'(last_waddr), 32'd2);
    check("add_wdata", 32'(last_wdata), 32'd12);
    check("add_reg", 32'(regs[2]), 32'd12);
    check("add_ret", 32'(retired), 32'd1);
    check("add_pc", 32'(pc), 32'd1);

    start = 1'b1;
    run_instr(3, cyc, req, wes, incs, brs);
    start = 1'b0;
    check("sub_cyc", cyc, 7);
    check("sub_req", req, 4);
    check("sub_waddr", 32'(last_waddr), 32'd3);
    check("sub_wdata", 32'(last_wdata), 32'd3);
    check("sub_ret", 32'(retired), 32'd2);
    check("sub_pc", 32'(pc), 32'd2);

    alu_halt = 1'b1;
    run_instr(0, cyc, req, wes, incs, brs);
    alu_halt = 1'b0;
    check("ahalt_cyc", cyc, 3);
    check("ahalt_pulses", wes + incs + brs, 0);
    check("ahalt_st", 32'({halted, busy}), 32'b10);
    check("ahalt_reg", 32'(regs[2]), 32'd12);
    check("ahalt_pc", 32'(pc), 32'd2);
    check("ahalt_ret", 32'(retired), 32'd2);

    pulse_start();
    run_instr(0, cyc, req, wes, incs, brs);
    check("xor_wdata", 32'(last_wdata), 32'd9);
    check("xor_pc", 32'(pc), 32'd3);
    check("xor_ret", 32'(retired), 32'd3);

    run_instr(0, cyc, req, wes, incs, brs);
    check("brt_br", brs, 1);
    check("brt_inc", incs, 0);
    check("brt_we", wes, 0);
    check("brt_addr", 32'(last_baddr), 32'h155);
    check("brt_pc", 32'(pc), 32'h155);

    run_instr(0, cyc, req, wes, incs, brs);
    check("brn_br", brs, 0);
    check("brn_inc", incs, 1);
    check("brn_pc", 32'(pc), 32'h156);
    check("brn_ret", 32'(retired), 32'd5);

    run_instr(0, cyc, req, wes, incs, brs);
    check("halt_cyc", cyc, 3);
    check("halt_we", wes + incs + brs, 0);
    check("halt_st", 32'({halted, busy}), 32'b10);
    check("halt_pc", 32'(pc), 32'h156);
    check("halt_ret", 32'(retired), 32'd5);

    alu_halt = 1'b1;
    pulse_start();
    check("resume", 32'({imem_req, busy, halted}), 32'b110);
    run_instr(0, cyc, req, wes, incs, brs);
    alu_halt = 1'b0;
    check("dhalt_cyc", cyc, 3);
    check("dhalt_st", 32'(halted), 32'd1);

    pulse_start();
    run_instr(1000, cyc, req, wes, incs, brs);
    check("to_cyc", cyc, 4);
    check("to_req", req, 4);
    check("to_st", 32'({fault, halted, imem_req}), 32'b110);
    check("to_ret", 32'(retired), 32'd5);
    pulse_start();
    check("to_clr", 32'({fault, busy, imem_req}), 32'b011);

    reset_n = 1'b0;
    tick();
    reset_n   = 1'b1;
    ack_delay = 0;
    check("rst2_pc", 32'(pc), 32'd0);
    pulse_start();
    tick();
    tick();
    check("exec_busy", 32'({busy, we, raddr1}), 32'b1_0_001);
    #1;
    reset_n = 1'b0;
    #1;
    check("abort_ctl", 32'({imem_req, pc_inc, branch, we, busy,
      halted, fault, raddr1, raddr2, waddr, alu_ctrl}), 32'd0);
    check("abort_cnt", 32'({retired, branch_addr}), 32'd0);
    tick();
    check("abort_reg", 32'(regs[2]), 32'd9);
    check("abort_pc", 32'(pc), 32'd0);
    reset_n = 1'b1;
    tick();
    check("abort_idle", 32'({busy, halted, imem_req}), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
      checks, errors);
    $finish;
  end

endmodule
